adc_seq_ctrl: RTL and testbench
===============================

ADC_SEQ_CTRL -- requirements
Module: adc_seq_ctrl

Interface
REQ-001 Parameter SIZE, default 8, SAR resolution in bits.
REQ-002 Parameter NCH, default 4, number of analog input channels.
REQ-003 Parameter SAMPLE_CYC, default 4, track/hold cycles per conversion (>=1).
REQ-004 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port rst  input  1  reset, synchronous and active-high.
REQ-006 Port start  input  1  single-shot request; one conversion on the next enabled channel.
REQ-007 Port en  input  1  continuous scan enable.
REQ-008 Port ch_mask  input  NCH  channel enable mask.
REQ-009 Port cmp  input  1  comparator output; 1 = analog input >= DAC level.
REQ-010 Port dac_code  output  SIZE  DAC trial code.
REQ-011 Port ch_sel  output  clog2(NCH)  input mux select.
REQ-012 Port sample  output  1  track/hold control; 1 = track.
REQ-013 Port busy  output  1  high in every state except IDLE.
REQ-014 Port done  output  1  one-cycle pulse when a result is valid.
REQ-015 Port data  output  SIZE  last result, held until the next done.
REQ-016 Port data_ch  output  clog2(NCH)  channel of data.
REQ-017 Port rd_sel  input  clog2(NCH)  result-bank read index.
REQ-018 Port rd_data  output  SIZE  combinational read of the per-channel result bank.

Function
REQ-019 FSM states SHALL be IDLE, SAMPLE, CONV and DONE.
REQ-020 IDLE->SAMPLE at an edge where (start|en)=1 and ch_mask!=0; ch_sel is loaded with the next enabled channel at that same edge.
REQ-021 Next channel SHALL be chosen round-robin: the first set mask bit after the last converted channel, wrapping NCH-1->0; the first choice after reset starts the search at channel 0.
REQ-022 SAMPLE SHALL last exactly SAMPLE_CYC cycles with sample=1 and dac_code=0; the last cycle moves to CONV and loads dac_code = 1<<(SIZE-1).
REQ-023 CONV SHALL last exactly SIZE cycles with sample=0; the cycle for bit i (MSB first) presents dac_code with bit i set.
REQ-024 At the end of each CONV cycle: bit i is kept if cmp=1, else cleared; bit i-1 is then set; after bit 0 the state moves to DONE.
REQ-025 DONE SHALL last one cycle and perform all of the following:
  - assert done;
  - present data and data_ch;
  - write the result into bank[ch_sel].
REQ-026 Latency from the start-accepting edge to done high SHALL be SAMPLE_CYC+SIZE+1 cycles (13 at the defaults).
REQ-027 DONE->SAMPLE on the next channel if en=1 and ch_mask!=0; otherwise DONE->IDLE; a pending start is not required in DONE.
REQ-028 start while busy SHALL be ignored and SHALL NOT be queued.
REQ-029 en deasserted mid-conversion: the current conversion completes, then the FSM returns to IDLE.
REQ-030 ch_mask changes mid-conversion affect only the next channel selection.
REQ-031 ch_mask changes never abort a conversion.
REQ-032 If ch_mask=0 at a DONE exit, the next state SHALL be IDLE.
REQ-033 A channel that is not yet converted SHALL read 0 from the bank.

Reset
REQ-034 rst SHALL force, on the next edge, regardless of state:
  - state=IDLE;
  - dac_code=0, ch_sel=0, sample=0, busy=0, done=0;
  - data=0, data_ch=0, all bank entries=0;
  - round-robin pointer back to "before channel 0".
REQ-035 rst SHALL take priority over start and en in the same cycle.

Structure
REQ-036 The FSM state enum and the SIZE/NCH/SAMPLE_CYC defaults SHALL live in shared package adc_pkg.
REQ-037 Round-robin channel selection SHALL be the sub-module adc_rr_pick, purely combinational: mask + last channel -> next channel + valid.

Verification
REQ-038 Bench comparator model: cmp = (vin[ch_sel] >= dac_code).
REQ-039 Single shot, mask=4'b0001, vin0=8'hA5: pulse start -> done exactly 13 cycles later, data=8'hA5, data_ch=0, dac_code sequence 80,C0,A0,B0,A8,A4,A6,A5.
REQ-040 Boundaries, one start each:
  - vin=8'h00 -> data=8'h00;
  - vin=8'hFF -> data=8'hFF.
REQ-041 en=1, mask=4'b1011, vin={40,30,20,10}: data_ch sequence 0,1,3,0,1,3; bank reads 10,20,?,40 with channel 2 reading 00.
REQ-042 start pulsed during CONV -> no extra done; en dropped mid-CONV -> exactly one more done, then busy=0.
REQ-043 Mask 0 + start -> busy stays 0; rst asserted mid-CONV -> next cycle all outputs and bank = 0, and the next start converts channel 0 first.

Source files
------------

// File: rtl/adc_pkg.sv
// adc_pkg: shared FSM state type and default parameters for the SAR ADC sequencer
package adc_pkg;
   localparam int DEF_SIZE = 8;
   localparam int DEF_NCH = 4;
   localparam int DEF_SAMPLE_CYC = 4;
   typedef enum logic [1:0] {IDLE, SAMPLE, CONV, DONE} state_t;
endpackage

// File: rtl/adc_rr_pick.sv
// adc_rr_pick: first enabled channel after last_ch, wrapping NCH-1 -> 0
module adc_rr_pick
   import adc_pkg::*;
#(
   parameter int NCH = DEF_NCH,
   localparam int CW = $clog2(NCH)
) (
   input  logic [NCH-1:0] mask,
   input  logic [CW-1:0]  last_ch,
   output logic [CW-1:0]  next_ch,
   output logic           valid
);
   logic [CW-1:0] idx;
   always_comb begin
      next_ch = '0;
      valid = 1'b0;
      idx = '0;
      for (int k = NCH; k >= 1; k--) begin
         idx = CW'((int'(last_ch) + k) % NCH);
         if (mask[idx]) begin
            next_ch = idx;
            valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/adc_seq_ctrl.sv
// adc_seq_ctrl: round-robin multi-channel SAR ADC sequencer with per-channel result bank
module adc_seq_ctrl
   import adc_pkg::*;
#(
   parameter int SIZE = DEF_SIZE,
   parameter int NCH = DEF_NCH,
   parameter int SAMPLE_CYC = DEF_SAMPLE_CYC,
   localparam int CW = $clog2(NCH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            en,
   input  logic [NCH-1:0]  ch_mask,
   input  logic            cmp,
   output logic [SIZE-1:0] dac_code,
   output logic [CW-1:0]   ch_sel,
   output logic            sample,
   output logic            busy,
   output logic            done,
   output logic [SIZE-1:0] data,
   output logic [CW-1:0]   data_ch,
   input  logic [CW-1:0]   rd_sel,
   output logic [SIZE-1:0] rd_data
);
   localparam int CNTW = $clog2(SAMPLE_CYC + 1);
   localparam int BW = $clog2(SIZE);
   state_t state, state_nxt;
   logic [CNTW-1:0] cnt;
   logic [BW-1:0] bit_idx;
   logic [CW-1:0] last_ch, pick;
   logic pick_valid;
   logic [SIZE-1:0] trial;
   logic [SIZE-1:0] bank [NCH];

   adc_rr_pick #(.NCH(NCH)) u_pick (
      .mask(ch_mask),
      .last_ch(last_ch),
      .next_ch(pick),
      .valid(pick_valid)
   );

   assign sample = state == SAMPLE;
   assign busy = state != IDLE;
   assign done = state == DONE;
   assign rd_data = bank[rd_sel];
   assign trial = cmp ? dac_code : dac_code & ~(SIZE'(1) << bit_idx);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   state_nxt = ((start | en) && pick_valid) ? SAMPLE : IDLE;
         SAMPLE: state_nxt = (cnt == CNTW'(SAMPLE_CYC - 1)) ? CONV : SAMPLE;
         CONV:   state_nxt = (bit_idx == '0) ? DONE : CONV;
         DONE:   state_nxt = (en && pick_valid) ? SAMPLE : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // last_ch resets to NCH-1 so the first search begins at channel 0
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         bit_idx <= '0;
         dac_code <= '0;
         ch_sel <= '0;
         last_ch <= CW'(NCH - 1);
         data <= '0;
         data_ch <= '0;
         for (int i = 0; i < NCH; i++) bank[i] <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE, DONE: if (state_nxt == SAMPLE) begin
               ch_sel <= pick;
               last_ch <= pick;
               cnt <= '0;
            end
            SAMPLE: begin
               cnt <= cnt + 1'b1;
               if (state_nxt == CONV) begin
                  dac_code <= SIZE'(1) << (SIZE - 1);
                  bit_idx <= BW'(SIZE - 1);
               end
            end
            CONV: if (bit_idx == '0) begin
               data <= trial;
               data_ch <= ch_sel;
               bank[ch_sel] <= trial;
               dac_code <= '0;
            end else begin
               dac_code <= trial | (SIZE'(1) << (bit_idx - 1'b1));
               bit_idx <= bit_idx - 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_adc_seq_ctrl.sv
// tb_adc_seq_ctrl: directed self-checking bench for adc_seq_ctrl with an ideal comparator
module tb_adc_seq_ctrl;
   logic clk = 1'b0, rst, start, en, cmp, sample, busy, done;
   logic [3:0] ch_mask;
   logic [7:0] dac_code, data, rd_data;
   logic [1:0] ch_sel, data_ch, rd_sel;
   logic [7:0] vin [4];
   int checks = 0, errors = 0;

   always #5 clk = ~clk;
   assign cmp = vin[ch_sel] >= dac_code;

   adc_seq_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .en(en), .ch_mask(ch_mask), .cmp(cmp),
      .dac_code(dac_code), .ch_sel(ch_sel), .sample(sample), .busy(busy), .done(done),
      .data(data), .data_ch(data_ch), .rd_sel(rd_sel), .rd_data(rd_data)
   );

   task automatic wait_done(output int cyc);
      cyc = -1;
      for (int n = 1; n <= 100; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            cyc = n;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, sample, dac_code, ch_sel, data, data_ch} !== 23'h0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b done=%b sample=%b dac=%h ch_sel=%0d data=%h data_ch=%0d, want all 0",
                  busy, done, sample, dac_code, ch_sel, data, data_ch);
      end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rd_sel = 2'(i);
         #1;
         checks++;
         if (rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_bank[%0d]: got %h want 00", i, rd_data);
         end
      end
   endtask

   task automatic test_single;
      logic [7:0] seq [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
      ch_mask = 4'b0001;
      vin[0] = 8'hA5;
      start = 1'b1;
      for (int n = 1; n <= 14; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (n <= 4) begin
            checks++;
            if ({sample, dac_code} !== {1'b1, 8'h00}) begin
               errors++;
               $display("FAIL single_sample c%0d: got sample=%b dac=%h want sample=1 dac=00", n, sample, dac_code);
            end
         end else if (n <= 12) begin
            checks++;
            if ({sample, dac_code} !== {1'b0, seq[n-5]}) begin
               errors++;
               $display("FAIL single_dac c%0d: got sample=%b dac=%h want sample=0 dac=%h", n, sample, dac_code, seq[n-5]);
            end
         end
         checks++;
         if (done !== (n == 13)) begin
            errors++;
            $display("FAIL single_done c%0d: got %b want %b", n, done, n == 13);
         end
         if (n == 13) begin
            checks++;
            if ({data, data_ch} !== {8'hA5, 2'd0}) begin
               errors++;
               $display("FAIL single_data: got %h ch%0d want a5 ch0", data, data_ch);
            end
         end
         if (n == 14) begin
            checks++;
            if (busy !== 1'b0) begin
               errors++;
               $display("FAIL single_idle: busy got %b want 0", busy);
            end
         end
      end
   endtask

   task automatic test_boundary;
      logic [7:0] vals [2] = '{8'h00, 8'hFF};
      int cyc;
      ch_mask = 4'b0001;
      for (int i = 0; i < 2; i++) begin
         vin[0] = vals[i];
         start = 1'b1;
         wait_done(cyc);
         checks++;
         if (cyc != 13 || data !== vals[i]) begin
            errors++;
            $display("FAIL boundary_%h: got data=%h latency=%0d want data=%h latency=13", vals[i], data, cyc, vals[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_scan;
      logic [1:0] exp_ch [6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
      logic [7:0] exp_bank [4] = '{8'h10, 8'h20, 8'h00, 8'h40};
      int k = 0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vin[0] = 8'h10; vin[1] = 8'h20; vin[2] = 8'h30; vin[3] = 8'h40;
      ch_mask = 4'b1011;
      en = 1'b1;
      for (int n = 0; n < 200 && k < 6; n++) begin
         @(negedge clk);
         if (done) begin
            checks++;
            if (data_ch !== exp_ch[k] || data !== vin[exp_ch[k]]) begin
               errors++;
               $display("FAIL scan_%0d: got ch%0d data=%h want ch%0d data=%h", k, data_ch, data, exp_ch[k], vin[exp_ch[k]]);
            end
            k++;
         end
      end
      en = 1'b0;
      checks++;
      if (k != 6) begin
         errors++;
         $display("FAIL scan_count: got %0d dones want 6", k);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL scan_stop: busy got %b want 0", busy);
      end
      for (int i = 0; i < 4; i++) begin
         rd_sel = 2'(i);
         #1;
         checks++;
         if (rd_data !== exp_bank[i]) begin
            errors++;
            $display("FAIL scan_bank[%0d]: got %h want %h", i, rd_data, exp_bank[i]);
         end
      end
   endtask

   task automatic test_start_ignored;
      int cnt = 0;
      ch_mask = 4'b0001;
      vin[0] = 8'h3C;
      start = 1'b1;
      repeat (6) @(negedge clk);
      start = 1'b1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) cnt++;
      end
      checks++;
      if (cnt != 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL start_ignored: got %0d dones busy=%b want 1 done busy=0", cnt, busy);
      end
   endtask

   task automatic test_en_drop;
      int cnt = 0;
      ch_mask = 4'b0001;
      vin[0] = 8'h5A;
      en = 1'b1;
      repeat (8) @(negedge clk);
      en = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (done) begin
            cnt++;
            checks++;
            if (data !== 8'h5A) begin
               errors++;
               $display("FAIL en_drop_data: got %h want 5a", data);
            end
         end
      end
      checks++;
      if (cnt != 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL en_drop: got %0d dones busy=%b want 1 done busy=0", cnt, busy);
      end
   endtask

   task automatic test_mask_zero;
      logic seen = 1'b0;
      ch_mask = 4'b0000;
      start = 1'b1;
      en = 1'b1;
      repeat (5) begin
         @(negedge clk);
         seen |= busy;
      end
      start = 1'b0;
      en = 1'b0;
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL mask_zero: busy seen %b want 0", seen);
      end
   endtask

   task automatic test_reset_mid;
      int cyc;
      ch_mask = 4'b0011;
      vin[0] = 8'h33;
      vin[1] = 8'h77;
      start = 1'b1;
      repeat (7) begin
         @(negedge clk);
         start = 1'b0;
      end
      start = 1'b1;
      en = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      start = 1'b0;
      en = 1'b0;
      rst = 1'b0;
      checks++;
      if ({busy, done, sample, dac_code, ch_sel, data, data_ch} !== 23'h0) begin
         errors++;
         $display("FAIL reset_mid_outputs: got busy=%b done=%b sample=%b dac=%h ch_sel=%0d data=%h data_ch=%0d, want all 0",
                  busy, done, sample, dac_code, ch_sel, data, data_ch);
      end
      for (int i = 0; i < 4; i++) begin
         rd_sel = 2'(i);
         #1;
         checks++;
         if (rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_bank[%0d]: got %h want 00", i, rd_data);
         end
      end
      @(negedge clk);
      start = 1'b1;
      wait_done(cyc);
      checks++;
      if (cyc != 13 || data_ch !== 2'd0 || data !== 8'h33) begin
         errors++;
         $display("FAIL reset_mid_restart: got ch%0d data=%h latency=%0d want ch0 data=33 latency=13", data_ch, data, cyc);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; en = 1'b0; ch_mask = 4'b0; rd_sel = 2'd0;
      for (int i = 0; i < 4; i++) vin[i] = 8'h00;
      @(negedge clk);
      test_reset;
      test_single;
      test_boundary;
      test_scan;
      test_start_ignored;
      test_en_drop;
      test_mask_zero;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
